// File: rtl/hs_pkg.sv
// Shared types and helpers for the handshake divide-by-N counter.
package hs_pkg;
  localparam int HS_MAX_STAGES = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    FWD     = 3'd2,
    FWD_ACK = 3'd3,
    RTZ     = 3'd4
  } hs_state_e;

  typedef logic [HS_MAX_STAGES:0] hs_term_t;

  // A limit of 0 stands for the full 2^stages ratio.
  function automatic hs_term_t hs_term(input logic [HS_MAX_STAGES-1:0] lim, input int stages);
    if (lim == '0) return hs_term_t'(1) << stages;
    return hs_term_t'(lim);
  endfunction
endpackage

// File: rtl/hs_sync.sv
// Reset-to-0 flop synchroniser of configurable depth; depth 0 is a wire.
module hs_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_ff
      logic [DEPTH:0] chain;
      assign chain[0] = d_i;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain[DEPTH:1] <= '0;
        else        chain[DEPTH:1] <= chain[DEPTH-1:0];
      end
      assign q_o = chain[DEPTH];
    end
  endgenerate
endmodule

// File: rtl/hs_divider_counter.sv
// 4-phase handshake divide-by-term stage: forwards one output token per term input tokens.
module hs_divider_counter
  import hs_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ri,
  output logic              ai,
  output logic              ro,
  input  logic              ao,
  input  logic [STAGES-1:0] limit,
  input  logic              clear,
  output logic [STAGES-1:0] count,
  output logic              busy
);
  logic s_ri, s_ao;
  hs_state_e state_q, state_d;
  logic [STAGES-1:0] count_q, count_d;
  logic pend_q, pend_d;
  logic ai_q, ro_q, busy_q;
  hs_term_t term, term_m1;
  logic wrap;

  hs_sync #(.DEPTH(SYNC_STAGES)) u_sync_ri (.clk(clk), .rst_n(rst_n), .d_i(ri), .q_o(s_ri));
  hs_sync #(.DEPTH(SYNC_STAGES)) u_sync_ao (.clk(clk), .rst_n(rst_n), .d_i(ao), .q_o(s_ao));

  // >= rather than == so a limit lowered below count wraps on the next token.
  assign term    = hs_term(HS_MAX_STAGES'(limit), STAGES);
  assign term_m1 = term - hs_term_t'(1);
  assign wrap    = hs_term_t'(count_q) >= term_m1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pend_d  = pend_q | clear;
    case (state_q)
      IDLE: begin
        if (s_ri) begin
          if (wrap) state_d = FWD;
          else begin
            count_d = count_q + 1'b1;
            state_d = ACK;
          end
        end else if (clear || pend_q) begin
          count_d = '0;
          pend_d  = 1'b0;
        end
      end
      ACK:     if (!s_ri) state_d = IDLE;
      FWD: begin
        if (s_ao) begin
          count_d = '0;
          state_d = FWD_ACK;
        end
      end
      FWD_ACK: if (!s_ri) state_d = RTZ;
      RTZ:     if (!s_ao) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are flopped from the next state so every pin is a register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pend_q  <= 1'b0;
      ai_q    <= 1'b0;
      ro_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      ai_q    <= (state_d == ACK) || (state_d == FWD_ACK);
      ro_q    <= (state_d == FWD) || (state_d == FWD_ACK);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ai    = ai_q;
  assign ro    = ro_q;
  assign busy  = busy_q;
  assign count = count_q;
endmodule

// File: tb/tb_hs_divider_counter.sv
// Directed bench for hs_divider_counter (STAGES=4, SYNC_STAGES=2).
module tb_hs_divider_counter;
  logic clk = 1'b0;
  logic rst_n, ri, ao, clear;
  logic [3:0] limit;
  logic ai, ro, busy;
  logic [3:0] count;
  int checks = 0, failures = 0;
  int nout = 0;
  logic auto_ao = 1'b0;

  hs_divider_counter #(.STAGES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ri(ri), .ai(ai), .ro(ro), .ao(ao),
    .limit(limit), .clear(clear), .count(count), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge ro); nout++; end
  initial forever begin @(posedge clk); #1; if (auto_ao) ao = ro; end
  initial begin #3000000; $display("FAIL watchdog observed=timeout expected=finish"); $fatal(1); end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel: 0=ai 1=ro 2=busy; samples 1 time unit after each rising edge
  task automatic wait_for(input int sel, input logic val, input string tag, output int cyc);
    logic got;
    cyc = 0;
    got = ~val;
    while (cyc < 200 && got !== val) begin
      @(posedge clk); #1;
      cyc++;
      got = (sel == 0) ? ai : (sel == 1) ? ro : busy;
    end
    if (got !== val) chk({tag, "_timeout"}, got, val);
  endtask

  task automatic token(output int lat, output logic ao_at_ai, output logic ro_at_ai);
    int c;
    @(posedge clk); #1;
    ri = 1'b1;
    wait_for(0, 1'b1, "ai_rise", lat);
    ao_at_ai = ao;
    ro_at_ai = ro;
    ri = 1'b0;
    wait_for(0, 1'b0, "ai_fall", c);
    wait_for(2, 1'b0, "idle", c);
  endtask

  int lat, c, base;
  logic a1, r1;

  initial begin
    rst_n = 1'b0; ri = 1'b0; ao = 1'b0; clear = 1'b0; limit = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {ai, ro, busy, count}, 7'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_outs", {ai, ro, busy, count}, 7'h00);

    // full ratio 16
    auto_ao = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      token(lat, a1, r1);
      chk($sformatf("cnt16_tok%0d", k), count, k);
    end
    chk("nout_before16", nout, 0);
    token(lat, a1, r1);
    chk("tok16_ao_before_ai", {a1, r1}, 2'b11);
    chk("nout_after16", nout, 1);
    chk("cnt_wrap16", count, 0);

    // limit 3: wraps on 3, 6, 9; latency pin->ai is 3 cycles
    limit = 4'd3;
    base = nout;
    for (int k = 1; k <= 9; k++) begin
      token(lat, a1, r1);
      if (k == 1) chk("lat_ai", lat, 3);
      if (k % 3 == 0) chk($sformatf("nout_lim3_tok%0d", k), nout - base, k / 3);
      else            chk($sformatf("cnt_lim3_tok%0d", k), count, k % 3);
    end
    chk("cnt_lim3_end", count, 0);

    // lowered limit below current count
    limit = 4'd0;
    for (int k = 1; k <= 10; k++) token(lat, a1, r1);
    chk("cnt_ten", count, 10);
    limit = 4'd4;
    base = nout;
    token(lat, a1, r1);
    chk("lowered_fwd", nout - base, 1);
    chk("lowered_cnt0", count, 0);

    // clear while in ACK
    limit = 4'd0;
    for (int k = 1; k <= 5; k++) token(lat, a1, r1);
    chk("cnt_five", count, 5);
    @(posedge clk); #1;
    ri = 1'b1;
    wait_for(0, 1'b1, "ack_ai", c);
    chk("ack_cnt6", count, 6);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("ack_clear_hold", count, 6);
    ri = 1'b0;
    wait_for(2, 1'b0, "ack_idle", c);
    chk("idle_entry_cnt6", count, 6);
    @(posedge clk); #1;
    chk("pend_clear_applied", count, 0);

    // clear in IDLE
    token(lat, a1, r1);
    token(lat, a1, r1);
    chk("cnt_two", count, 2);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("idle_clear", count, 0);

    // term 1 with output stalled
    limit = 4'd1;
    auto_ao = 1'b0;
    ao = 1'b0;
    @(posedge clk); #1;
    ri = 1'b1;
    wait_for(1, 1'b1, "stall_ro", c);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_%0d", k), {ai, busy, count}, 6'b01_0000);
    end

    // async reset in FWD
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ro", {ro, ai, busy}, 3'b000);
    ri = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_idle", {ai, ro, busy, count}, 7'h00);

    // term 1 forwards every token
    auto_ao = 1'b1;
    base = nout;
    for (int k = 1; k <= 3; k++) begin
      token(lat, a1, r1);
      chk($sformatf("t1_cnt_tok%0d", k), count, 0);
    end
    chk("t1_nout", nout - base, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hs_divider_counter.md
# hs_divider_counter

Clocked, parametrised successor to the gate-level handshake counter chain. It consumes 4-phase request/acknowledge tokens on its input channel and forwards one token on its output channel for every `term` input tokens, where `term` is run-time programmable up to 2^STAGES. It also exposes the current count, which the self-timed chain cannot. It sits between a token producer and consumer as a divide-by-N event stage, with optional input synchronisers for use on asynchronous boundaries.

## Interface
- `STAGES`, 4: counter width in bits; maximum divide ratio 2^STAGES (legal 1..16).
- `SYNC_STAGES`, 2: flops on each of `ri` and `ao` before use (0 = inputs already synchronous to `clk`; otherwise 2 or 3).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ri`  in  1  input-channel request (4-phase).
- `ai`  out  1  input-channel acknowledge.
- `ro`  out  1  output-channel request (4-phase).
- `ao`  in  1  output-channel acknowledge.
- `limit`  in  STAGES  terminal count; 0 encodes 2^STAGES.
- `clear`  in  1  synchronous request to zero `count`.
- `count`  out  STAGES  input tokens accepted since last wrap/clear.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset: state IDLE; `ai`=0, `ro`=0, `count`=0, `busy`=0, synchroniser flops 0, pending-clear 0.
- `term` = (`limit`==0) ? 2^STAGES : `limit`. `limit` is sampled only in IDLE.
- States and transitions (s_ri/s_ao = synchronised inputs):
  - IDLE (ai=0, ro=0): if s_ri=1 and `count` >= `term`-1 -> FWD; else if s_ri=1 -> `count`+1, ACK.
  - ACK (ai=1): s_ri=0 -> IDLE.
  - FWD (ro=1, ai=0): s_ao=1 -> `count`<=0, FWD_ACK.
  - FWD_ACK (ai=1, ro=1): s_ri=0 -> RTZ.
  - RTZ (ai=0, ro=0): s_ao=0 -> IDLE.
- The wrapping input token is not acknowledged until the output channel has acknowledged (back-pressure, as in the gate-level stage).
- The `>=` compare makes a `limit` lowered below the current `count` wrap on the next token rather than run to 2^STAGES.
- `term`=1: every input token is forwarded; `count` stays 0.
- `clear`: in IDLE with s_ri=0 it zeroes `count` next cycle. Otherwise it sets pending-clear, which is applied on the next entry to IDLE. If `clear` and an IDLE token acceptance coincide, the token wins and pending-clear is set.
- Protocol violations, such as `ri` falling in FWD or `ao` rising outside FWD, are ignored. The state waits for the legal edge.
- `count` arithmetic is modulo 2^STAGES; no overflow flag.

## Timing
- All outputs are registered and change only on `clk` rising edges, except reset, which clears asynchronously.
- Latency from an input edge at the pin to the responding output edge is `SYNC_STAGES`+1 cycles (1 cycle when `SYNC_STAGES`=0).
- Minimum non-wrapping token, with inputs responding immediately, is 2×(`SYNC_STAGES`+1) cycles. A wrapping token adds the output handshake round trip.
- Reset mid-handshake drops `ai` and `ro` immediately. The environment must return `ri`/`ao` to 0 before the next token.

## Structure
- Shared package `hs_pkg`: the state enum (IDLE, ACK, FWD, FWD_ACK, RTZ) and the helper function computing `term` from `limit`.
- Sub-module `hs_sync`: a parametrised-depth, reset-to-0 synchroniser, instantiated for `ri` and `ao`. It is a pass-through when depth is 0.
- The top level holds the FSM, the counter and the pending-clear flag.

## Test plan
- Reset with `ri`=`ao`=0 -> `ai`=`ro`=`count`=`busy`=0. Assert `rst_n` in FWD -> `ro` drops without waiting for `clk`.
- `limit`=0, STAGES=4, 16 tokens with `ao` responding -> exactly 1 output handshake on token 16; `count` goes 1..15 then 0; `ai` for token 16 rises only after `ao`=1.
- `limit`=3 -> output handshakes on tokens 3, 6, 9. With `SYNC_STAGES`=2, `ai` rises 3 cycles after `ri`.
- `count`=10, then set `limit`=4 -> the next token forwards and `count` returns to 0.
- Assert `clear` during ACK with `count`=5 -> `count` stays 6 until IDLE, then 0 the cycle after.
- `limit`=1 -> every token forwards; hold `ao`=0 for 20 cycles -> `ai` stays 0 and `busy`=1 throughout.
